// File: rtl/mc_isa_pkg.sv
// ISA constants, ALU codes, control-unit state and mux-select encodings for the
// 16-bit TSC-style multi-cycle CPU.
package mc_isa_pkg;

    typedef enum logic [3:0] {
        OP_BNE   = 4'd0,
        OP_BEQ   = 4'd1,
        OP_BGZ   = 4'd2,
        OP_BLZ   = 4'd3,
        OP_ADI   = 4'd4,
        OP_ORI   = 4'd5,
        OP_LHI   = 4'd6,
        OP_LWD   = 4'd7,
        OP_SWD   = 4'd8,
        OP_JMP   = 4'd9,
        OP_JAL   = 4'd10,
        OP_RTYPE = 4'd15
    } opcode_t;

    typedef enum logic [5:0] {
        FN_JPR = 6'd25,
        FN_JRL = 6'd26,
        FN_WWD = 6'd28,
        FN_HLT = 6'd29
    } funct_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_ORR = 4'd3,
        ALU_NOT = 4'd4,
        ALU_TCP = 4'd5,
        ALU_SHL = 4'd6,
        ALU_SHR = 4'd7,
        ALU_LHI = 4'd8,
        ALU_BNE = 4'd10,
        ALU_BEQ = 4'd11,
        ALU_BGZ = 4'd12,
        ALU_BLZ = 4'd13
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RS     = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        DST_9_8  = 2'd0,
        DST_7_6  = 2'd1,
        DST_LINK = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC1 = 2'd2
    } wb_src_t;

    typedef enum logic [3:0] {
        CL_RALU,
        CL_IMM,
        CL_LWD,
        CL_SWD,
        CL_BRANCH,
        CL_JMP,
        CL_JAL,
        CL_JPR,
        CL_JRL,
        CL_WWD,
        CL_HLT,
        CL_NOP
    } iclass_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Memory handshake bundle between the control unit (master) and the memory
// port (slave).
interface mc_control_unit_if;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
    modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies the instruction register and
// produces the ALU operation and operand-B controls.
module mc_decode
    import mc_isa_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] instr,
    output iclass_t              iclass,
    output logic [3:0]           alu_op,
    output logic                 alu_src_b,
    output logic                 ext_sel
);

    logic [3:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[WORD_SIZE-1 -: 4];
    assign funct         = instr[5:0];
    assign unused_fields = &{1'b0, instr[WORD_SIZE-5:6]};

    // Loads and stores also use the ALU to form rs + sign-extended offset.
    always_comb begin
        iclass    = CL_NOP;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        ext_sel   = 1'b1;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
                iclass = CL_BRANCH;
                alu_op = ALU_BNE + {2'b00, opcode[1:0]};
            end
            OP_ADI: begin iclass = CL_IMM; alu_op = ALU_ADD; alu_src_b = 1'b1; end
            OP_ORI: begin iclass = CL_IMM; alu_op = ALU_ORR; alu_src_b = 1'b1; ext_sel = 1'b0; end
            OP_LHI: begin iclass = CL_IMM; alu_op = ALU_LHI; alu_src_b = 1'b1; end
            OP_LWD: begin iclass = CL_LWD; alu_src_b = 1'b1; end
            OP_SWD: begin iclass = CL_SWD; alu_src_b = 1'b1; end
            OP_JMP: iclass = CL_JMP;
            OP_JAL: iclass = CL_JAL;
            OP_RTYPE: begin
                if (funct[5:3] == 3'b000) begin
                    iclass = CL_RALU;
                    alu_op = {1'b0, funct[2:0]};
                end else begin
                    case (funct)
                        FN_JPR:  iclass = CL_JPR;
                        FN_JRL:  iclass = CL_JRL;
                        FN_WWD:  iclass = CL_WWD;
                        FN_HLT:  iclass = CL_HLT;
                        default: iclass = CL_NOP;
                    endcase
                end
            end
            default: iclass = CL_NOP;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: IF/ID/EX/MEM/WB/HALT sequencer with retired-instruction
// counter. Define MC_CTRL_WAIT_EN to make IF and MEM wait on mem_ready.
module mc_control_unit
    import mc_isa_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 Reset_N,
    mc_control_unit_if.master    mem,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 bcond,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           wb_src,
    output logic                 alu_src_b,
    output logic                 ext_sel,
    output logic [3:0]           alu_op,
    output logic                 out_write,
    output logic [CNT_W-1:0]     num_inst,
    output logic                 is_halted
);

    state_t     state, next_state;
    iclass_t    iclass;
    logic [3:0] dec_alu_op;
    logic       dec_alu_src_b, dec_ext_sel;
    logic       ready, count_inc;

`ifdef MC_CTRL_WAIT_EN
    assign ready = mem.mem_ready;
`else
    logic unused_ready;
    assign unused_ready = mem.mem_ready;
    assign ready        = 1'b1;
`endif

    mc_decode #(.WORD_SIZE(WORD_SIZE)) u_decode (
        .instr     (instr),
        .iclass    (iclass),
        .alu_op    (dec_alu_op),
        .alu_src_b (dec_alu_src_b),
        .ext_sel   (dec_ext_sel)
    );

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state    <= S_IF;
            num_inst <= '0;
        end else begin
            state <= next_state;
            if (count_inc) num_inst <= num_inst + CNT_W'(1);
        end
    end

    // Every strobe is gated by Reset_N so the async reset silences the datapath at once.
    always_comb begin
        next_state    = state;
        count_inc     = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.i_or_d    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_NEXT;
        reg_write     = 1'b0;
        reg_dst       = DST_9_8;
        wb_src        = WB_ALU;
        alu_src_b     = 1'b0;
        ext_sel       = 1'b0;
        alu_op        = ALU_ADD;
        out_write     = 1'b0;
        is_halted     = 1'b0;
        if (Reset_N) begin
            if (state inside {S_ID, S_EX, S_MEM, S_WB}) begin
                alu_op    = dec_alu_op;
                alu_src_b = dec_alu_src_b;
                ext_sel   = dec_ext_sel;
            end
            case (state)
                S_IF: begin
                    mem.mem_read = 1'b1;
                    if (ready) begin
                        ir_write   = 1'b1;
                        next_state = S_ID;
                    end
                end
                S_ID: begin
                    next_state = S_IF;
                    pc_write   = 1'b1;
                    count_inc  = 1'b1;
                    case (iclass)
                        CL_RALU, CL_IMM, CL_LWD, CL_SWD, CL_BRANCH: begin
                            pc_write   = 1'b0;
                            count_inc  = 1'b0;
                            next_state = S_EX;
                        end
                        CL_JMP: pc_src = PC_JUMP;
                        CL_JAL: begin
                            pc_src = PC_JUMP; reg_write = 1'b1; reg_dst = DST_LINK; wb_src = WB_PC1;
                        end
                        CL_JPR: pc_src = PC_RS;
                        CL_JRL: begin
                            pc_src = PC_RS; reg_write = 1'b1; reg_dst = DST_LINK; wb_src = WB_PC1;
                        end
                        CL_WWD: out_write = 1'b1;
                        CL_HLT: begin
                            pc_write   = 1'b0;
                            next_state = S_HALT;
                        end
                        default: pc_src = PC_NEXT;
                    endcase
                end
                S_EX: begin
                    case (iclass)
                        CL_BRANCH: begin
                            pc_write   = 1'b1;
                            count_inc  = 1'b1;
                            pc_src     = bcond ? PC_BRANCH : PC_NEXT;
                            next_state = S_IF;
                        end
                        CL_LWD, CL_SWD:  next_state = S_MEM;
                        CL_RALU, CL_IMM: next_state = S_WB;
                        default:         next_state = S_IF;
                    endcase
                end
                S_MEM: begin
                    mem.mem_read  = (iclass == CL_LWD);
                    mem.mem_write = (iclass == CL_SWD);
                    mem.i_or_d    = 1'b1;
                    if (ready) begin
                        if (iclass == CL_LWD) begin
                            next_state = S_WB;
                        end else begin
                            pc_write   = 1'b1;
                            count_inc  = 1'b1;
                            next_state = S_IF;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (iclass == CL_RALU) ? DST_7_6 : DST_9_8;
                    wb_src     = (iclass == CL_LWD) ? WB_MEM : WB_ALU;
                    pc_write   = 1'b1;
                    count_inc  = 1'b1;
                    next_state = S_IF;
                end
                S_HALT:  is_halted = 1'b1;
                default: next_state = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-cycle expected control vectors are
// derived from the instruction-class timing rules and checked by a monitor.
module tb_mc_control_unit;

    localparam int WS = 16;
    localparam int CW = 4;
`ifdef MC_CTRL_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int C_RALU = 0, C_IMM = 1, C_LWD = 2, C_SWD = 3, C_BR = 4, C_JMP = 5;
    localparam int C_JAL = 6, C_JPR = 7, C_JRL = 8, C_WWD = 9, C_HLT = 10, C_NOP = 11;

    typedef enum int {K_IF_WAIT, K_IF, K_ID, K_EX, K_MEM_WAIT, K_MEM, K_WB} kind_t;

    typedef struct packed {
        logic          mem_read;
        logic          mem_write;
        logic          i_or_d;
        logic          ir_write;
        logic          pc_write;
        logic [1:0]    pc_src;
        logic          reg_write;
        logic [1:0]    reg_dst;
        logic [1:0]    wb_src;
        logic          alu_src_b;
        logic          ext_sel;
        logic [3:0]    alu_op;
        logic          out_write;
        logic          is_halted;
        logic [CW-1:0] num_inst;
    } obs_t;

    typedef struct {
        obs_t  v;
        obs_t  care;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt    = 0;

    logic          clk     = 1'b0;
    logic          Reset_N = 1'b0;
    logic [WS-1:0] instr   = '0;
    logic          bcond   = 1'b0;
    logic          ir_write, pc_write, reg_write, alu_src_b, ext_sel, out_write, is_halted;
    logic [1:0]    pc_src, reg_dst, wb_src;
    logic [3:0]    alu_op;
    logic [CW-1:0] num_inst;

    mc_control_unit_if mem_bus ();

    mc_control_unit #(.WORD_SIZE(WS), .CNT_W(CW)) dut (
        .clk       (clk),
        .Reset_N   (Reset_N),
        .mem       (mem_bus),
        .instr     (instr),
        .bcond     (bcond),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .alu_src_b (alu_src_b),
        .ext_sel   (ext_sel),
        .alu_op    (alu_op),
        .out_write (out_write),
        .num_inst  (num_inst),
        .is_halted (is_halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        obs_t act;
        act.mem_read  = mem_bus.mem_read;
        act.mem_write = mem_bus.mem_write;
        act.i_or_d    = mem_bus.i_or_d;
        act.ir_write  = ir_write;
        act.pc_write  = pc_write;
        act.pc_src    = pc_src;
        act.reg_write = reg_write;
        act.reg_dst   = reg_dst;
        act.wb_src    = wb_src;
        act.alu_src_b = alu_src_b;
        act.ext_sel   = ext_sel;
        act.alu_op    = alu_op;
        act.out_write = out_write;
        act.is_halted = is_halted;
        act.num_inst  = num_inst;
        checks++;
        if (((act ^ e.v) & e.care) != '0) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h care=%h", e.tag, act, e.v, e.care);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t care_default();
        obs_t c;
        c           = '1;
        c.pc_src    = '0;
        c.reg_dst   = '0;
        c.wb_src    = '0;
        c.alu_src_b = 1'b0;
        c.ext_sel   = 1'b0;
        c.alu_op    = '0;
        return c;
    endfunction

    task automatic push(input obs_t v, input obs_t c, input string tag);
        exp_t e;
        e.v    = v;
        e.care = c;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    function automatic int classify(input logic [WS-1:0] ins);
        int op, fn;
        op = int'(ins[15:12]);
        fn = int'(ins[5:0]);
        if (op <= 3) return C_BR;
        if (op >= 4 && op <= 6) return C_IMM;
        if (op == 7) return C_LWD;
        if (op == 8) return C_SWD;
        if (op == 9) return C_JMP;
        if (op == 10) return C_JAL;
        if (op == 15) begin
            if (fn <= 7) return C_RALU;
            if (fn == 25) return C_JPR;
            if (fn == 26) return C_JRL;
            if (fn == 28) return C_WWD;
            if (fn == 29) return C_HLT;
        end
        return C_NOP;
    endfunction

    task automatic applyReset(input int n);
        obs_t v;
        for (int k = 0; k < n; k++) begin
            tick();
            Reset_N = 1'b0;
            cnt     = 0;
            v       = '0;
            push(v, '1, "reset");
        end
    endtask

    task automatic applyStimulus(input logic [WS-1:0] ins, input int w_if, input int w_mem,
                                 input int bc, input int abort_at, input int halt_cycles,
                                 input string name);
        kind_t      ph[$];
        obs_t       v, cr;
        int         c, op, fn, wi, wm;
        bit         ret, link;
        logic [1:0] ps;
        logic       rdy, bcv;
        c  = classify(ins);
        op = int'(ins[15:12]);
        fn = int'(ins[5:0]);
        wi = WAIT_EN ? w_if : 0;
        wm = WAIT_EN ? w_mem : 0;
        repeat (wi) ph.push_back(K_IF_WAIT);
        ph.push_back(K_IF);
        ph.push_back(K_ID);
        if (c inside {C_RALU, C_IMM, C_LWD, C_SWD, C_BR}) ph.push_back(K_EX);
        if (c == C_LWD || c == C_SWD) begin
            repeat (wm) ph.push_back(K_MEM_WAIT);
            ph.push_back(K_MEM);
        end
        if (c inside {C_RALU, C_IMM, C_LWD}) ph.push_back(K_WB);

        for (int i = 0; i < ph.size(); i++) begin
            tick();
            Reset_N = 1'b1;
            if (i == abort_at) begin
                Reset_N = 1'b0;
                cnt     = 0;
                v       = '0;
                push(v, '1, {name, " abort"});
                applyReset(2);
                return;
            end
            instr = ins;
            rdy   = 1'($urandom_range(0, 1));
            if (WAIT_EN) begin
                if (ph[i] == K_IF_WAIT || ph[i] == K_MEM_WAIT) rdy = 1'b0;
                else if (ph[i] == K_IF || ph[i] == K_MEM) rdy = 1'b1;
            end
            bcv = (bc < 0) ? 1'($urandom_range(0, 1)) : bc[0];
            mem_bus.mem_ready = rdy;
            bcond             = bcv;

            v    = '0;
            cr   = care_default();
            ret  = 1'b0;
            link = 1'b0;
            ps   = 2'd0;
            case (ph[i])
                K_IF_WAIT: v.mem_read = 1'b1;
                K_IF: begin v.mem_read = 1'b1; v.ir_write = 1'b1; end
                K_ID: begin
                    case (c)
                        C_JMP: begin ret = 1'b1; ps = 2'd2; end
                        C_JAL: begin ret = 1'b1; ps = 2'd2; link = 1'b1; end
                        C_JPR: begin ret = 1'b1; ps = 2'd3; end
                        C_JRL: begin ret = 1'b1; ps = 2'd3; link = 1'b1; end
                        C_WWD: begin ret = 1'b1; v.out_write = 1'b1; end
                        C_NOP: ret = 1'b1;
                        default: ;
                    endcase
                end
                K_EX: if (c == C_BR) begin ret = 1'b1; ps = bcv ? 2'd1 : 2'd0; end
                K_MEM_WAIT, K_MEM: begin
                    v.i_or_d    = 1'b1;
                    v.mem_read  = (c == C_LWD);
                    v.mem_write = (c == C_SWD);
                    if (ph[i] == K_MEM && c == C_SWD) ret = 1'b1;
                end
                K_WB: begin
                    ret         = 1'b1;
                    v.reg_write = 1'b1;
                    v.reg_dst   = (c == C_RALU) ? 2'd1 : 2'd0;
                    v.wb_src    = (c == C_LWD) ? 2'd1 : 2'd0;
                end
                default: ;
            endcase
            if (link) begin
                v.reg_write = 1'b1;
                v.reg_dst   = 2'd2;
                v.wb_src    = 2'd2;
            end
            if (ph[i] != K_IF && ph[i] != K_IF_WAIT) begin
                if (c == C_RALU) begin
                    v.alu_op  = 4'(fn);
                    cr.alu_op = '1;
                end else if (c == C_IMM) begin
                    v.alu_op     = (op == 4) ? 4'd0 : (op == 5) ? 4'd3 : 4'd8;
                    v.alu_src_b  = 1'b1;
                    v.ext_sel    = (op != 5);
                    cr.alu_op    = '1;
                    cr.alu_src_b = 1'b1;
                    cr.ext_sel   = 1'b1;
                end else if (c == C_BR) begin
                    v.alu_op  = 4'(10 + op);
                    cr.alu_op = '1;
                end
            end
            if (ret) begin
                v.pc_write = 1'b1;
                v.pc_src   = ps;
                cr.pc_src  = '1;
            end
            if (v.reg_write) begin
                cr.reg_dst = '1;
                cr.wb_src  = '1;
            end
            v.num_inst = CW'(cnt);
            push(v, cr, $sformatf("%s cyc%0d", name, i));
            if (ret || (c == C_HLT && ph[i] == K_ID)) cnt = (cnt + 1) % (1 << CW);
        end

        if (c == C_HLT) begin
            repeat (halt_cycles) begin
                tick();
                mem_bus.mem_ready = 1'($urandom_range(0, 1));
                bcond             = 1'($urandom_range(0, 1));
                v                 = '0;
                v.is_halted       = 1'b1;
                v.num_inst        = CW'(cnt);
                cr                = care_default();
                push(v, cr, {name, " halted"});
            end
            applyReset(2);
        end
    endtask

    initial begin
        logic [WS-1:0] ins;
        int            r, ab;
        mem_bus.mem_ready = 1'b0;
        applyReset(3);

        applyStimulus(16'h41FD, 0, 0, -1, -1, 0, "adi");
        applyStimulus(16'h7100, 0, 2, -1, -1, 0, "lwd_wait");
        applyStimulus(16'h1000, 0, 0, 1, -1, 0, "beq_taken");
        applyStimulus(16'h1000, 0, 0, 0, -1, 0, "beq_not");
        applyStimulus(16'hA005, 0, 0, -1, -1, 0, "jal");
        applyStimulus(16'hF01A, 0, 0, -1, -1, 0, "jrl");
        applyReset(2);
        applyStimulus(16'hF01C, 0, 0, -1, -1, 0, "wwd");
        applyStimulus(16'hF01D, 0, 0, -1, -1, 20, "hlt");
        applyStimulus(16'h8100, 0, 0, -1, 2, 0, "swd_abort");
        applyStimulus(16'hC123, 1, 0, -1, -1, 0, "nop_op");
        applyStimulus(16'hF03F, 0, 0, -1, -1, 0, "nop_funct");

        for (int n = 0; n < 300; n++) begin
            ins            = WS'($urandom);
            ins[15:12]     = 4'($urandom_range(0, 15));
            if (ins[15:12] == 4'd15) begin
                r = int'($urandom_range(0, 9));
                case (r)
                    0, 1, 2, 3: ins[5:0] = 6'($urandom_range(0, 7));
                    4:       ins[5:0] = 6'd25;
                    5:       ins[5:0] = 6'd26;
                    6:       ins[5:0] = 6'd28;
                    7:       ins[5:0] = 6'd29;
                    default: ins[5:0] = 6'($urandom);
                endcase
            end
            ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 3)) : -1;
            applyStimulus(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1, ab,
                          int'($urandom_range(2, 6)), "rand");
        end

        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multi-cycle control unit for the 16-bit TSC-style CPU. It sequences the IF/ID/EX/MEM/WB states per instruction class and drives every datapath strobe and mux select. It adds a memory ready/wait handshake, a retired-instruction counter and a halt state. It sits between the instruction register and the datapath, replacing the fixed-latency controller.

## Interface
- WORD_SIZE, 16, instruction/data width; opcode = instr[WORD_SIZE-1 -: 4], funct = instr[5:0]
- CNT_W, 16, width of num_inst
- clk  in  1  clock, rising edge
- Reset_N  in  1  asynchronous, active-low reset; clock clk
- instr  in  WORD_SIZE  instruction register contents, stable from ID onward
- mem_ready  in  1  memory completes the current access this cycle
- bcond  in  1  branch condition from ALU, valid in EX
- mem_read / mem_write  out  1  memory strobes
- i_or_d  out  1  0 = address from PC, 1 = address from ALU result
- ir_write  out  1  load instruction register
- pc_write  out  1  PC update strobe
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump target, 3 = rs
- reg_write  out  1  register file write
- reg_dst  out  2  0 = instr[9:8], 1 = instr[7:6], 2 = register 2 (link)
- wb_src  out  2  0 = ALU, 1 = memory, 2 = PC+1
- alu_src_b  out  1  0 = rt, 1 = extended immediate
- ext_sel  out  1  1 = sign-extend imm8, 0 = zero-extend imm8
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 NOT, 5 TCP, 6 SHL, 7 SHR, 8 LHI, 10 BNE, 11 BEQ, 12 BGZ, 13 BLZ
- out_write  out  1  WWD: latch rs into output_port
- num_inst  out  CNT_W  retired-instruction count
- is_halted  out  1  HLT executed

## Operation
- States: IF, ID, EX, MEM, WB, HALT. Outputs are Moore-decoded from the state and instr. While Reset_N is low, all strobes are 0.
- IF: mem_read=1, i_or_d=0. When mem_ready is high, ir_write=1 and the next state is ID.
- Instruction paths ("retire" means pc_write=1 plus a num_inst increment in that cycle):
  - R-ALU (op 15, funct 0–7): IF, ID, EX, WB. alu_op=funct. WB does reg_write with reg_dst=1, wb_src=0, and retires with pc_src=0.
  - ADI(4) / ORI(5) / LHI(6): IF, ID, EX, WB. alu_src_b=1. ext_sel=0 only for ORI. WB writes with reg_dst=0 and retires.
  - LWD(7): IF, ID, EX, MEM, WB. MEM: mem_read=1, i_or_d=1. WB: wb_src=1, reg_dst=0, retires.
  - SWD(8): IF, ID, EX, MEM. MEM: mem_write=1, i_or_d=1, retires on completion.
  - BNE/BEQ/BGZ/BLZ (0–3): IF, ID, EX. EX retires with pc_src = bcond ? 1 : 0. BGZ and BLZ are signed compares.
  - JMP(9): retires in ID with pc_src=2. JAL(10): ID also does reg_write with reg_dst=2, wb_src=2.
  - JPR (funct 25): retires in ID with pc_src=3. JRL (funct 26): same, plus the link write.
  - WWD (funct 28): ID asserts out_write=1 and retires with pc_src=0.
  - HLT (funct 29): ID does num_inst+1, then HALT. HALT holds with all strobes 0 and is_halted=1 until reset.
  - Undefined opcode or funct: NOP; retires in ID with pc_src=0.
- MEM with mem_ready low: hold MEM and keep the strobes asserted. No retire until ready.
- num_inst wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous) forces: state=IF, num_inst=0, is_halted=0, all outputs 0. The first fetch happens in the first cycle after Reset_N rises.
- Reset mid-instruction: the partial instruction is abandoned with no retire.
- Latency with zero waits, in cycles: JMP/JAL/JPR/JRL/WWD/HLT/NOP 2, branch 3, R-ALU/imm 4, SWD 4, LWD 5. Each wait cycle adds 1.
- alu_op, ext_sel and alu_src_b are valid from ID until the instruction ends.
- Exactly one pc_write pulse per retired instruction, except HLT, which has none.

## Configuration
- MC_CTRL_WAIT_EN defined: IF and MEM honour mem_ready as described above.
- MC_CTRL_WAIT_EN undefined: mem_ready is ignored and memory is treated as always ready, so IF and MEM each last exactly 1 cycle.

## Structure
- Package mc_isa_pkg holds:
  - opcode and funct constants
  - alu_op codes
  - state enum
  - pc_src, reg_dst and wb_src encodings
- Sub-module mc_decode (combinational): maps instr to instruction class and alu_op; instantiated once.

## Test plan
- ADI r1,r0,-3 after reset, zero waits: IF→ID→EX→WB in 4 cycles; WB shows reg_write=1, reg_dst=0, ext_sel=1, pc_write=1; num_inst goes 0→1.
- LWD with mem_ready low for 2 MEM cycles: MEM is held 3 cycles with mem_read=1, i_or_d=1; total 7 cycles; a single pc_write.
- BEQ, once with bcond=1 and once with bcond=0: EX shows pc_src=1 and pc_src=0 respectively; both take 3 cycles.
- JAL then JRL: each takes 2 cycles; ID shows reg_write=1, reg_dst=2, wb_src=2, with pc_src=2 and pc_src=3 respectively.
- WWD then HLT: out_write pulses for 1 cycle; is_halted=1 stays set for 20 cycles with no strobes; num_inst=2.
- Reset asserted mid-EX of SWD: no mem_write occurs; outputs go to 0 immediately; num_inst=0; the fetch restarts at IF after release.
